mont_redc_serial: RTL and testbench

- Sequential Montgomery reduction (REDC) stage, directly downstream of the double-width modular add/sub stage in the BLS12-381 datapath.
- Consumes a 2W-bit double-precision value T, where 0 <= T < p·2^W.
- Produces the single-width residue T·2^(-W) mod p, fully reduced to [0, p).
- Radix-2, bit-serial: one reduction step per cycle. Uses valid/ready handshakes on both sides.

---
 rtl/mont_redc_serial.sv | 71 +++++++
 tb/tb_mont_redc_serial.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mont_redc_serial.sv
// mont_redc_serial: bit-serial radix-2 Montgomery reduction, T*2^-W mod P.
`ifndef WORD_SIZE
`define WORD_SIZE 384
`endif
`ifndef BLS381_CHAR
`define BLS381_CHAR 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab
`endif
module mont_redc_serial #(
  parameter int W = `WORD_SIZE,
  parameter logic [W-1:0] P = `BLS381_CHAR,
  parameter int CW = $clog2(W) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
);
  localparam logic [1:0] IDLE = 2'd0, ITER = 2'd1, FINAL = 2'd2, DONE = 2'd3;
  localparam logic [2*W:0] PX = {{(W+1){1'b0}}, P};
  logic [1:0] state_q, state_d;
  logic [2*W:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] res_q, res_d;
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_data = res_q;
  always_comb begin
    sum = acc_q + (acc_q[0] ? PX : '0);
    state_d = state_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (in_valid) begin
        acc_d = {1'b0, in_data};
        cnt_d = '0;
        state_d = ITER;
      end
      ITER: begin
        acc_d = sum >> 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(W - 1) ? FINAL : ITER;
      end
      // acc < 2P here, so the result fits in W bits and low-word subtraction is exact
      FINAL: begin
        res_d = acc_q >= PX ? acc_q[W-1:0] - P : acc_q[W-1:0];
        state_d = DONE;
      end
      default: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_mont_redc_serial.sv
// tb_mont_redc_serial: scoreboard bench for the serial Montgomery reduction stage.
module tb_mont_redc_serial;
  localparam int W = 384;
  localparam logic [W-1:0] P = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
  typedef struct {
    logic [2*W-1:0] t;
    bit k;
    logic [W-1:0] e;
  } item_t;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [2*W-1:0] in_data = '0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] out_data;
  item_t q[$];
  int passed = 0, total = 0, hits = 0, cyc = 0;
  mont_redc_serial #(.W(W), .P(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (dut.state_q == 2'd2 && dut.acc_q >= {{(W+1){1'b0}}, P}) hits <= hits + 1;
  function automatic void chk(input bit ok, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction
  function automatic logic [2*W-1:0] mk(input logic [W-1:0] k);
    return {k, {W{1'b0}}};
  endfunction
  always @(negedge clk) begin
    item_t it;
    logic [2*W-1:0] lhs, rhs;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk(0, "unexpected_output", out_data, '0);
      else begin
        it = q.pop_front();
        if (it.k) chk(out_data == it.e, "result", out_data, it.e);
        else begin
          lhs = {out_data, {W{1'b0}}} % {{W{1'b0}}, P};
          rhs = it.t % {{W{1'b0}}, P};
          chk(out_data < P && lhs == rhs, "residue", lhs[W-1:0], rhs[W-1:0]);
        end
      end
    end
  end
  task automatic send(input logic [2*W-1:0] t, input bit k, input logic [W-1:0] e);
    int n = 0;
    in_valid = 1;
    in_data = t;
    while (!in_ready && n < 2*W) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk(0, "accept_timeout", W'(n), W'(2*W));
    q.push_back('{t, k, e});
    @(posedge clk); #1;
    in_valid = 0;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 2*W) begin
      @(posedge clk); #1; n++;
    end
    chk(in_ready, "ready_timeout", W'(in_ready), W'(1));
  endtask
  task automatic run(input logic [2*W-1:0] t, input bit k, input logic [W-1:0] e);
    send(t, k, e);
    wait_ready();
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int c, ta[4];
    logic [W-1:0] hi, lo;
    repeat (3) @(posedge clk);
    #1;
    chk(in_ready && !out_valid && !busy, "reset_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    chk(out_data == '0, "reset_data", out_data, '0);
    rst = 0;
    send('0, 1, '0);
    c = 0;
    while (!out_valid && c < 2*W) begin
      @(posedge clk); #1; c++;
    end
    chk(c == W + 1, "latency", W'(c), W'(W + 1));
    chk(busy, "busy_done", W'(busy), W'(1));
    @(posedge clk); #1;
    chk(in_ready && !out_valid, "ready_after_xfer", W'({in_ready, out_valid}), W'(2'b10));
    run(mk(5), 1, 5);
    run(mk(P - 1), 1, P - 1);
    run(mk(1), 1, 1);
    run(mk(123456789), 1, 123456789);
    run(2*W'(1), 0, '0);
    run({P - 1, {W{1'b1}}}, 0, '0);
    for (int i = 0; i < 36; i++) begin
      for (int j = 0; j < W / 32; j++) begin
        hi[j*32 +: 32] = $urandom;
        lo[j*32 +: 32] = $urandom;
      end
      run({hi % P, lo}, 0, '0);
    end
    chk(hits > 0, "subtract_branch_hit", W'(hits), W'(1));
    out_ready = 0;
    send(mk(7), 1, 7);
    c = 0;
    while (!out_valid && c < 2*W) begin
      @(posedge clk); #1; c++;
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = i[0];
      in_data = mk(W'(i + 40));
      @(posedge clk); #1;
      chk(out_valid && !in_ready && out_data == 7, "backpressure_hold", out_data, 7);
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk); #1;
    chk(!out_valid && in_ready, "bp_release", W'({out_valid, in_ready}), W'(2'b01));
    send(mk(9), 1, 9);
    repeat (100) @(posedge clk);
    #1;
    chk(dut.cnt_q == 100, "abort_point", W'(dut.cnt_q), W'(100));
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    q.delete();
    chk(in_ready && !out_valid && !busy, "mid_reset", W'({in_ready, out_valid, busy}), W'(3'b100));
    run(mk(3), 1, 3);
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_data = mk(W'(i + 11));
      c = 0;
      while (!in_ready && c < 2*W) begin
        @(posedge clk); #1; c++;
      end
      q.push_back('{in_data, 1, W'(i + 11)});
      @(posedge clk); #1;
      ta[i] = cyc;
      if (i > 0) chk(ta[i] - ta[i-1] == W + 3, "b2b_spacing", W'(ta[i] - ta[i-1]), W'(W + 3));
    end
    in_valid = 0;
    wait_ready();
    repeat (2) @(posedge clk);
    chk(q.size() == 0, "queue_drained", W'(q.size()), '0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
